avalon_example_host: RTL and testbench

- Avalon-MM host that drives the two agent ports of the example peripheral: the register port and the memory port.
- Takes one command at a time on a simple valid/ready command interface and decodes the byte address to a region.
- Issues a single-cycle read or write strobe on that region, waits for read data, and returns one response per command.
- Used as the bus-side front end in system builds and as the reusable driver in peripheral benches.

---
 rtl/avalon_example_host_if.sv | 42 ++++
 rtl/avalon_example_host.sv | 217 +++++++++++++++++++++
 tb/tb_avalon_example_host.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_example_host_if.sv
// Bus bundle for avalon_example_host: the command/response channel plus the
// register-port and memory-port Avalon-MM agent signals.
interface avalon_example_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic        reg_read;
  logic        reg_write;
  logic [2:0]  reg_address;
  logic [31:0] reg_wdata;
  logic        reg_read_valid;
  logic [31:0] reg_rdata;

  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_address;
  logic [31:0] mem_wdata;
  logic        mem_read_valid;
  logic [31:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
           reg_read_valid, reg_rdata, mem_read_valid, mem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           reg_read, reg_write, reg_address, reg_wdata,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata,
           reg_read_valid, reg_rdata, mem_read_valid, mem_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           reg_read, reg_write, reg_address, reg_wdata,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/avalon_example_host.sv
// Avalon-MM host: one command at a time, decoded to the register or memory agent.
// Optional edge-detected interrupt pulse output enabled by defining AVALON_HOST_IRQ_EN.
module avalon_example_host #(
  parameter logic [31:0] REG_BASE       = 32'd0,
  parameter logic [31:0] REG_SPAN       = 32'd32,
  parameter logic [31:0] MEM_BASE       = 32'd1024,
  parameter logic [31:0] MEM_SPAN       = 32'd1024,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                   clk,
  input logic                   reset_n,
  avalon_example_host_if.master bus
`ifdef AVALON_HOST_IRQ_EN
  ,
  input  logic                  irq,
  output logic                  irq_pulse
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_e;
  typedef enum logic [1:0] {REGION_NONE, REGION_REG, REGION_MEM} region_e;

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  state_e      state_q;
  region_e     region_q;
  logic        isWrite_q;
  logic [15:0] waitCount_q;
  logic [15:0] waitCount_d;

  logic        cmdReady_q;
  logic        rspValid_q;
  logic [31:0] rspRdata_q;
  logic        rspError_q;

  logic        regRead_q;
  logic        regWrite_q;
  logic [2:0]  regAddress_q;
  logic [31:0] regWdata_q;
  logic        memRead_q;
  logic        memWrite_q;
  logic [7:0]  memAddress_q;
  logic [31:0] memWdata_q;

  logic [31:0] regOffset;
  logic [31:0] memOffset;
  region_e     cmdRegion;
  logic        selValid;
  logic [31:0] selRdata;

  // Offset-from-base compare covers both bounds in one unsigned test.
  assign regOffset   = bus.cmd_address - REG_BASE;
  assign memOffset   = bus.cmd_address - MEM_BASE;
  assign waitCount_d = waitCount_q + 16'd1;

  always_comb begin
    cmdRegion = REGION_NONE;
    if (regOffset < REG_SPAN) begin
      cmdRegion = REGION_REG;
    end else if (memOffset < MEM_SPAN) begin
      cmdRegion = REGION_MEM;
    end
  end

  always_comb begin
    selValid = 1'b0;
    selRdata = 32'd0;
    case (region_q)
      REGION_REG: begin
        selValid = bus.reg_read_valid;
        selRdata = bus.reg_rdata;
      end
      REGION_MEM: begin
        selValid = bus.mem_read_valid;
        selRdata = bus.mem_rdata;
      end
      default: begin
        selValid = 1'b0;
        selRdata = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      region_q     <= REGION_NONE;
      isWrite_q    <= 1'b0;
      waitCount_q  <= 16'd0;
      cmdReady_q   <= 1'b1;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= 32'd0;
      rspError_q   <= 1'b0;
      regRead_q    <= 1'b0;
      regWrite_q   <= 1'b0;
      regAddress_q <= 3'd0;
      regWdata_q   <= 32'd0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      memAddress_q <= 8'd0;
      memWdata_q   <= 32'd0;
    end else begin
      // Strobes and the response pulse are single-cycle by default.
      regRead_q  <= 1'b0;
      regWrite_q <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      rspValid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            state_q    <= ISSUE;
            cmdReady_q <= 1'b0;
            region_q   <= cmdRegion;
            isWrite_q  <= bus.cmd_write;
            case (cmdRegion)
              REGION_REG: begin
                regRead_q    <= !bus.cmd_write;
                regWrite_q   <= bus.cmd_write;
                regAddress_q <= regOffset[4:2];
                regWdata_q   <= bus.cmd_wdata;
              end
              REGION_MEM: begin
                memRead_q    <= !bus.cmd_write;
                memWrite_q   <= bus.cmd_write;
                memAddress_q <= memOffset[9:2];
                memWdata_q   <= bus.cmd_wdata;
              end
              default: begin
              end
            endcase
          end
        end

        ISSUE: begin
          if (region_q == REGION_NONE) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
            rspRdata_q <= 32'd0;
            rspError_q <= 1'b1;
          end else if (isWrite_q) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
            rspRdata_q <= 32'd0;
            rspError_q <= 1'b0;
          end else begin
            state_q     <= WAIT_RD;
            waitCount_q <= 16'd0;
          end
        end

        WAIT_RD: begin
          if (selValid) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
            rspRdata_q <= selRdata;
            rspError_q <= 1'b0;
          end else begin
            waitCount_q <= waitCount_d;
            if (waitCount_d == TimeoutLimit) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspRdata_q <= 32'd0;
              rspError_q <= 1'b1;
            end
          end
        end

        RESP: begin
          state_q    <= IDLE;
          cmdReady_q <= 1'b1;
        end

        default: begin
          state_q    <= IDLE;
          cmdReady_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmdReady_q;
  assign bus.rsp_valid   = rspValid_q;
  assign bus.rsp_rdata   = rspRdata_q;
  assign bus.rsp_error   = rspError_q;
  assign bus.reg_read    = regRead_q;
  assign bus.reg_write   = regWrite_q;
  assign bus.reg_address = regAddress_q;
  assign bus.reg_wdata   = regWdata_q;
  assign bus.mem_read    = memRead_q;
  assign bus.mem_write   = memWrite_q;
  assign bus.mem_address = memAddress_q;
  assign bus.mem_wdata   = memWdata_q;

`ifdef AVALON_HOST_IRQ_EN
  logic irqSync_q;
  logic irqPrev_q;
  logic irqPulse_q;

  // Edge detect on the registered copy so the pulse lands two cycles after the rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqSync_q  <= 1'b0;
      irqPrev_q  <= 1'b0;
      irqPulse_q <= 1'b0;
    end else begin
      irqSync_q  <= irq;
      irqPrev_q  <= irqSync_q;
      irqPulse_q <= irqSync_q & ~irqPrev_q;
    end
  end

  assign irq_pulse = irqPulse_q;
`endif

endmodule

// File: tb/tb_avalon_example_host.sv
// Directed bench for avalon_example_host with behavioural register and memory agents.
module tb_avalon_example_host;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   assertCount = 0;
  int   failCount = 0;

  avalon_example_host_if bus();

`ifdef AVALON_HOST_IRQ_EN
  logic irq = 1'b0;
  logic irqPulse;
`endif

  avalon_example_host #(.TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef AVALON_HOST_IRQ_EN
    ,
    .irq       (irq),
    .irq_pulse (irqPulse)
`endif
  );

  always #5 clk = ~clk;

  // Agent storage and read-latency knobs; a delay of 0 means the agent never answers.
  logic [31:0] memStore [256];
  logic [31:0] regStore [8];
  int          memDelay = 1;
  int          regDelay = 1;
  int          memCountdown = 0;
  int          regCountdown = 0;
  logic [31:0] memPendData = 32'd0;
  logic [31:0] regPendData = 32'd0;
  logic        memOwn = 1'b0;
  logic        regOwn = 1'b0;

  initial begin : agents
    for (int i = 0; i < 256; i++) memStore[i] = 32'd0;
    for (int i = 0; i < 8; i++) regStore[i] = 32'd0;
    forever begin
      @(negedge clk);
      if (memOwn) begin bus.mem_read_valid = 1'b0; memOwn = 1'b0; end
      if (regOwn) begin bus.reg_read_valid = 1'b0; regOwn = 1'b0; end
      if (memCountdown > 0) begin
        memCountdown--;
        if (memCountdown == 0) begin
          bus.mem_read_valid = 1'b1;
          bus.mem_rdata = memPendData;
          memOwn = 1'b1;
        end
      end
      if (regCountdown > 0) begin
        regCountdown--;
        if (regCountdown == 0) begin
          bus.reg_read_valid = 1'b1;
          bus.reg_rdata = regPendData;
          regOwn = 1'b1;
        end
      end
      if (bus.mem_write) memStore[bus.mem_address] = bus.mem_wdata;
      if (bus.reg_write) regStore[bus.reg_address] = bus.reg_wdata;
      if (bus.mem_read && memDelay > 0) begin
        memCountdown = memDelay;
        memPendData = memStore[bus.mem_address];
      end
      if (bus.reg_read && regDelay > 0) begin
        regCountdown = regDelay;
        regPendData = regStore[bus.reg_address];
      end
    end
  end

  // Strobe monitor: no two strobes together, never strobes on adjacent cycles.
  int   strobeViolations = 0;
  logic prevStrobe = 1'b0;
  initial begin : strobeMonitor
    logic [3:0] strobes;
    forever begin
      @(negedge clk);
      strobes = {bus.reg_read, bus.reg_write, bus.mem_read, bus.mem_write};
      if ($countones(strobes) > 1) strobeViolations++;
      if (strobes != 4'd0 && prevStrobe) strobeViolations++;
      prevStrobe = (strobes != 4'd0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Observations from the most recent command, cycle numbers relative to accept.
  logic        obsRsp;
  logic [31:0] obsRdata;
  logic        obsError;
  int          obsStrobeCyc;
  int          obsRspCyc;
  int          obsStrobeCnt;
  logic [3:0]  obsStrobeMask;
  logic [2:0]  obsRegAddr;
  logic [7:0]  obsMemAddr;
  logic [31:0] obsMemWdata;

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data);
    int waitCyc;
    logic [3:0] mask;
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = wr;
    bus.cmd_address = addr;
    bus.cmd_wdata   = data;
    waitCyc = 0;
    while (!bus.cmd_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("cmd accepted", {31'd0, bus.cmd_ready}, 32'd1);
    obsRsp = 1'b0; obsRdata = 32'hx; obsError = 1'bx;
    obsStrobeCyc = -1; obsRspCyc = -1; obsStrobeCnt = 0; obsStrobeMask = 4'd0;
    obsRegAddr = 3'hx; obsMemAddr = 8'hx; obsMemWdata = 32'hx;
    for (int k = 1; k <= 300 && !obsRsp; k++) begin
      @(negedge clk);
      if (k == 1) bus.cmd_valid = 1'b0;
      mask = {bus.reg_read, bus.reg_write, bus.mem_read, bus.mem_write};
      if (mask != 4'd0) begin
        obsStrobeCnt++;
        obsStrobeCyc = k;
        obsStrobeMask = mask;
        obsRegAddr = bus.reg_address;
        obsMemAddr = bus.mem_address;
        obsMemWdata = bus.mem_wdata;
      end
      if (bus.rsp_valid) begin
        obsRsp = 1'b1;
        obsRspCyc = k;
        obsRdata = bus.rsp_rdata;
        obsError = bus.rsp_error;
      end
    end
    bus.cmd_valid = 1'b0;
    checkOutput("rsp seen", {31'd0, obsRsp}, 32'd1);
    @(negedge clk);
    checkOutput("rsp one cycle", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("ready after rsp", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int seen;
    int pulseCyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_address = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.reg_read_valid = 1'b0;
    bus.reg_rdata = 32'd0;
    bus.mem_read_valid = 1'b0;
    bus.mem_rdata = 32'd0;

    // Reset values.
    #1 reset_n = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("reset cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    checkOutput("reset strobes", {28'd0, bus.reg_read, bus.reg_write, bus.mem_read, bus.mem_write}, 32'd0);
    checkOutput("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("reset rsp_error", {31'd0, bus.rsp_error}, 32'd0);
    checkOutput("reset mem_address", {24'd0, bus.mem_address}, 32'd0);
    checkOutput("reset reg_wdata", bus.reg_wdata, 32'd0);
    reset_n = 1'b1;

    // First memory write.
    applyStimulus(1'b1, 32'h400, 32'h400);
    checkOutput("w400 strobe mask", {28'd0, obsStrobeMask}, 32'h1);
    checkOutput("w400 strobe cyc", obsStrobeCyc, 32'd1);
    checkOutput("w400 mem_address", {24'd0, obsMemAddr}, 32'd0);
    checkOutput("w400 mem_wdata", obsMemWdata, 32'h400);
    checkOutput("w400 rsp cyc", obsRspCyc, 32'd2);
    checkOutput("w400 error", {31'd0, obsError}, 32'd0);

    // Memory sweep.
    memDelay = 1;
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b1, 32'd1024 + 32'(4 * k), 32'(k));
      checkOutput($sformatf("sweep wr addr %0d", k), {24'd0, obsMemAddr}, 32'(k));
    end
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b0, 32'd1024 + 32'(4 * k), 32'd0);
      checkOutput($sformatf("sweep rd data %0d", k), obsRdata, 32'(k));
      checkOutput($sformatf("sweep rd addr %0d", k), {24'd0, obsMemAddr}, 32'(k));
      checkOutput($sformatf("sweep rd err %0d", k), {31'd0, obsError}, 32'd0);
    end
    checkOutput("sweep rd latency", obsRspCyc, 32'd3);
    checkOutput("sweep rd mask", {28'd0, obsStrobeMask}, 32'h2);

    // Register path with a 3-cycle agent.
    regDelay = 3;
    applyStimulus(1'b1, 32'd4, 32'h3);
    checkOutput("reg wr mask", {28'd0, obsStrobeMask}, 32'h4);
    checkOutput("reg wr address", {29'd0, obsRegAddr}, 32'd1);
    checkOutput("reg wr rsp cyc", obsRspCyc, 32'd2);
    applyStimulus(1'b0, 32'd4, 32'd0);
    checkOutput("reg rd mask", {28'd0, obsStrobeMask}, 32'h8);
    checkOutput("reg rd address", {29'd0, obsRegAddr}, 32'd1);
    checkOutput("reg rd data", obsRdata, 32'h3);
    checkOutput("reg rd error", {31'd0, obsError}, 32'd0);
    checkOutput("reg rd rsp cyc", obsRspCyc, 32'd5);

    // Unmapped addresses.
    applyStimulus(1'b0, 32'd64, 32'd0);
    checkOutput("unmapped rd strobes", obsStrobeCnt, 32'd0);
    checkOutput("unmapped rd error", {31'd0, obsError}, 32'd1);
    checkOutput("unmapped rd rdata", obsRdata, 32'd0);
    checkOutput("unmapped rd rsp cyc", obsRspCyc, 32'd2);
    applyStimulus(1'b1, 32'd2048, 32'hABCD);
    checkOutput("unmapped wr strobes", obsStrobeCnt, 32'd0);
    checkOutput("unmapped wr error", {31'd0, obsError}, 32'd1);
    checkOutput("unmapped wr rdata", obsRdata, 32'd0);

    // Timeout with a stray memory valid pulse mid-wait.
    regDelay = 0;
    fork
      applyStimulus(1'b0, 32'd16, 32'd0);
      begin
        repeat (4) @(posedge clk);
        #2 bus.mem_read_valid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #2 bus.mem_read_valid = 1'b0;
      end
    join
    checkOutput("timeout mask", {28'd0, obsStrobeMask}, 32'h8);
    checkOutput("timeout reg_address", {29'd0, obsRegAddr}, 32'd4);
    checkOutput("timeout error", {31'd0, obsError}, 32'd1);
    checkOutput("timeout rdata", obsRdata, 32'd0);
    checkOutput("timeout rsp cyc", obsRspCyc, 32'd10);

    regDelay = 2;
    applyStimulus(1'b1, 32'd20, 32'h55);
    checkOutput("post-timeout wr error", {31'd0, obsError}, 32'd0);
    applyStimulus(1'b0, 32'd20, 32'd0);
    checkOutput("post-timeout rd data", obsRdata, 32'h55);
    checkOutput("post-timeout rd cyc", obsRspCyc, 32'd4);

    // Reset during WAIT_RD drops the command.
    regDelay = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_address = 32'd8;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("abort async ready", {31'd0, bus.cmd_ready}, 32'd1);
    checkOutput("abort strobes", {28'd0, bus.reg_read, bus.reg_write, bus.mem_read, bus.mem_write}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    checkOutput("abort no rsp", seen, 32'd0);
    checkOutput("abort idle ready", {31'd0, bus.cmd_ready}, 32'd1);
    regDelay = 1;
    applyStimulus(1'b0, 32'd4, 32'd0);
    checkOutput("abort recover data", obsRdata, 32'h3);
    checkOutput("abort recover cyc", obsRspCyc, 32'd3);

`ifdef AVALON_HOST_IRQ_EN
    @(negedge clk);
    irq = 1'b1;
    seen = 0;
    pulseCyc = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (irqPulse) begin
        seen++;
        pulseCyc = k;
      end
      if (k == 5) irq = 1'b0;
    end
    checkOutput("irq pulse count", seen, 32'd1);
    checkOutput("irq pulse cyc", pulseCyc, 32'd2);
`endif

    checkOutput("strobe overlap", strobeViolations, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
